// File: rtl/dsram_responder_if.sv
// rtl/dsram_responder_if.sv - request/response bundle between core (master) and data SRAM responder (slave)
interface dsram_responder_if;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req_en, req_wen, req_addr, req_wdata,
        input  addr_ok, data_ok, rdata, busy, err
    );

    modport slave (
        input  req_en, req_wen, req_addr, req_wdata,
        output addr_ok, data_ok, rdata, busy, err
    );
endinterface

// File: rtl/dsram_responder.sv
// rtl/dsram_responder.sv - multi-cycle byte-masked data SRAM responder; optional DSRAM_RANGE_CHECK_EN flags out-of-range addresses
module dsram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    dsram_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_idx;
    logic [3:0]        lat_wen;
    logic [31:0]       lat_wdata;
    logic              lat_oor;
    logic [31:0]       rdata_r;
    logic              err_r;
    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              exec;
    logic              waiting;
    logic              req_oor;
    logic [ADDR_W-1:0] exec_idx;
    logic [3:0]        exec_wen;
    logic [31:0]       exec_wdata;
    logic              exec_oor;
    logic              unused_addr_bits;

`ifdef DSRAM_RANGE_CHECK_EN
    assign req_oor          = (bus.req_addr[31:ADDR_W+2] != '0);
    assign unused_addr_bits = ^bus.req_addr[1:0];
`else
    assign req_oor          = 1'b0;
    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
`endif

    assign waiting = (state == WAIT);
    assign accept  = bus.req_en && bus.addr_ok;
    // At LATENCY=1 the execution edge is the accept edge itself, so the live request is used.
    assign exec    = waiting ? (cnt == 4'd1) : (accept && (LATENCY == 1));

    assign exec_idx   = waiting ? lat_idx   : bus.req_addr[ADDR_W+1:2];
    assign exec_wen   = waiting ? lat_wen   : bus.req_wen;
    assign exec_wdata = waiting ? lat_wdata : bus.req_wdata;
    assign exec_oor   = waiting ? lat_oor   : req_oor;

    assign bus.addr_ok = (state != WAIT);
    assign bus.data_ok = (state == RESP);
    assign bus.busy    = waiting;
    assign bus.rdata   = rdata_r;
    assign bus.err     = err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_wen   <= 4'd0;
            lat_wdata <= 32'd0;
            lat_oor   <= 1'b0;
            rdata_r   <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (exec) begin
                rdata_r <= exec_oor ? 32'd0 : mem[exec_idx];
                err_r   <= exec_oor;
            end
            case (state)
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                default: begin
                    if (accept) begin
                        lat_idx   <= bus.req_addr[ADDR_W+1:2];
                        lat_wen   <= bus.req_wen;
                        lat_wdata <= bus.req_wdata;
                        lat_oor   <= req_oor;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Memory is never reset; an edge with rst high must not commit a write.
    always_ff @(posedge clk) begin
        if (exec && !rst && !exec_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (exec_wen[i])
                    mem[exec_idx][8*i +: 8] <= exec_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dsram_responder.sv
// tb/tb_dsram_responder.sv - randomized self-checking bench for dsram_responder at LATENCY 1 and 3
module tb_dsram_responder;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] sh1 [1 << ADDR_W];
    logic [31:0] sh3 [1 << ADDR_W];

    dsram_responder_if bus1 ();
    dsram_responder_if bus3 ();

    dsram_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    dsram_responder #(.ADDR_W(ADDR_W), .LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    always #5 clk = ~clk;

    task automatic drive(input int sel, input logic en, input logic [31:0] addr,
                         input logic [3:0] wen, input logic [31:0] wdata);
        if (sel == 1) begin
            bus1.req_en = en; bus1.req_addr = addr; bus1.req_wen = wen; bus1.req_wdata = wdata;
        end else begin
            bus3.req_en = en; bus3.req_addr = addr; bus3.req_wen = wen; bus3.req_wdata = wdata;
        end
    endtask

    task automatic observe(input int sel, output logic a, output logic d, output logic [31:0] r,
                           output logic b, output logic e);
        if (sel == 1) begin
            a = bus1.addr_ok; d = bus1.data_ok; r = bus1.rdata; b = bus1.busy; e = bus1.err;
        end else begin
            a = bus3.addr_ok; d = bus3.data_ok; r = bus3.rdata; b = bus3.busy; e = bus3.err;
        end
    endtask

    // Reference: memory as an array of words, each access returns the old word then merges strobed bytes.
    task automatic model(input int sel, input logic [31:0] addr, input logic [3:0] wen,
                         input logic [31:0] wdata, output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        logic [31:0] old;
        logic [31:0] mask;
        idx = int'(addr[ADDR_W+1:2]);
`ifdef DSRAM_RANGE_CHECK_EN
        exp_err = ((addr >> (ADDR_W + 2)) != 0);
`else
        exp_err = 1'b0;
`endif
        if (exp_err) begin
            exp_rd = 32'd0;
            return;
        end
        old = (sel == 1) ? sh1[idx] : sh3[idx];
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{wen[b]}};
        exp_rd = old;
        if (sel == 1) sh1[idx] = (old & ~mask) | (wdata & mask);
        else          sh3[idx] = (old & ~mask) | (wdata & mask);
    endtask

    // Called at a negedge with addr_ok=1; returns at the negedge where data_ok is seen (or timeout).
    task automatic access(input int sel, input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                          output int lat);
        logic a, d, b, e;
        logic [31:0] r;
        drive(sel, 1'b1, addr, wen, wdata);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 32'd0, 4'd0, 32'd0);
        lat = 1;
        observe(sel, a, d, r, b, e);
        while (!d && lat < 40) begin
            @(negedge clk);
            lat++;
            observe(sel, a, d, r, b, e);
        end
        rd = r;
        er = e;
    endtask

    task automatic test_reset();
        logic a, d, b, e;
        logic [31:0] r;
        rst = 1'b1;
        drive(1, 1'b0, 32'd0, 4'd0, 32'd0);
        drive(3, 1'b0, 32'd0, 4'd0, 32'd0);
        repeat (2) @(negedge clk);
        for (int s = 1; s <= 3; s += 2) begin
            observe(s, a, d, r, b, e);
            checks++; if (d !== 1'b0)     begin failures++; $display("FAIL reset_data_ok lat%0d got=%b exp=0", s, d); end
            checks++; if (b !== 1'b0)     begin failures++; $display("FAIL reset_busy lat%0d got=%b exp=0", s, b); end
            checks++; if (a !== 1'b1)     begin failures++; $display("FAIL reset_addr_ok lat%0d got=%b exp=1", s, a); end
            checks++; if (r !== 32'd0)    begin failures++; $display("FAIL reset_rdata lat%0d got=%h exp=0", s, r); end
            checks++; if (e !== 1'b0)     begin failures++; $display("FAIL reset_err lat%0d got=%b exp=0", s, e); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full-word writes to words 0..15 of both instances so every later access has a defined prior value.
    task automatic test_init();
        logic [31:0] rd, er_rd;
        logic er;
        int lat;
        for (int s = 1; s <= 3; s += 2) begin
            for (int i = 0; i < 16; i++) begin
                model(s, 32'(i * 4), 4'hF, $urandom, er_rd, er);
                access(s, 32'(i * 4), 4'hF, (s == 1) ? sh1[i] : sh3[i], rd, er, lat);
                checks++; if (lat !== s) begin failures++; $display("FAIL init_latency lat%0d word=%0d got=%0d exp=%0d", s, i, lat, s); end
            end
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat;
        model(1, 32'h10, 4'hF, 32'hCAFEBABE, exp_rd, exp_er);
        access(1, 32'h10, 4'hF, 32'hCAFEBABE, rd, er, lat);
        checks++; if (lat !== 1)      begin failures++; $display("FAIL word_write_latency got=%0d exp=1", lat); end
        checks++; if (rd !== exp_rd)  begin failures++; $display("FAIL word_write_old_rdata got=%h exp=%h", rd, exp_rd); end
        model(1, 32'h10, 4'h0, 32'h0, exp_rd, exp_er);
        access(1, 32'h10, 4'h0, 32'h0, rd, er, lat);
        checks++; if (lat !== 1)            begin failures++; $display("FAIL word_read_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hCAFEBABE)  begin failures++; $display("FAIL word_read_rdata got=%h exp=cafebabe", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat;
        model(1, 32'h20, 4'hF, 32'h11223344, exp_rd, exp_er);
        access(1, 32'h20, 4'hF, 32'h11223344, rd, er, lat);
        model(1, 32'h20, 4'b0100, 32'h00AA0000, exp_rd, exp_er);
        access(1, 32'h20, 4'b0100, 32'h00AA0000, rd, er, lat);
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL lane_write_rdata got=%h exp=11223344", rd); end
        model(1, 32'h20, 4'h0, 32'h0, exp_rd, exp_er);
        access(1, 32'h20, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11AA3344) begin failures++; $display("FAIL lane_read_rdata got=%h exp=11aa3344", rd); end
    endtask

    task automatic test_back_to_back();
        logic a, d, b, e;
        logic [31:0] r, exp_w, exp_r;
        logic exp_er;
        model(1, 32'h30, 4'hF, 32'h5A5A5A5A, exp_w, exp_er);
        model(1, 32'h30, 4'h0, 32'h0, exp_r, exp_er);
        drive(1, 1'b1, 32'h30, 4'hF, 32'h5A5A5A5A);
        @(negedge clk);
        observe(1, a, d, r, b, e);
        checks++; if (a !== 1'b1)   begin failures++; $display("FAIL b2b_addr_ok_1 got=%b exp=1", a); end
        checks++; if (d !== 1'b1)   begin failures++; $display("FAIL b2b_data_ok_1 got=%b exp=1", d); end
        checks++; if (r !== exp_w)  begin failures++; $display("FAIL b2b_write_rdata got=%h exp=%h", r, exp_w); end
        drive(1, 1'b1, 32'h30, 4'h0, 32'h0);
        @(negedge clk);
        observe(1, a, d, r, b, e);
        checks++; if (a !== 1'b1)         begin failures++; $display("FAIL b2b_addr_ok_2 got=%b exp=1", a); end
        checks++; if (d !== 1'b1)         begin failures++; $display("FAIL b2b_data_ok_2 got=%b exp=1", d); end
        checks++; if (r !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_read_rdata got=%h exp=5a5a5a5a", r); end
        drive(1, 1'b0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        observe(1, a, d, r, b, e);
        checks++; if (d !== 1'b0) begin failures++; $display("FAIL b2b_data_ok_end got=%b exp=0", d); end
    endtask

    task automatic test_latency3();
        logic a, d, b, e;
        logic [31:0] r, exp_r, rd;
        logic exp_er, er;
        int lat;
        model(3, 32'h18, 4'h0, 32'h0, exp_r, exp_er);
        drive(3, 1'b1, 32'h18, 4'h0, 32'h0);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            observe(3, a, d, r, b, e);
            // Inject a write while WAIT; it must be ignored.
            if (k == 1) drive(3, 1'b1, 32'h1C, 4'hF, 32'hBAD0BAD0);
            else        drive(3, 1'b0, 32'd0, 4'd0, 32'd0);
            checks++; if (b !== (k <= 2))  begin failures++; $display("FAIL lat3_busy k=%0d got=%b exp=%b", k, b, (k <= 2)); end
            checks++; if (a !== (k > 2))   begin failures++; $display("FAIL lat3_addr_ok k=%0d got=%b exp=%b", k, a, (k > 2)); end
            checks++; if (d !== (k == 3))  begin failures++; $display("FAIL lat3_data_ok k=%0d got=%b exp=%b", k, d, (k == 3)); end
            if (k == 3) begin
                checks++; if (r !== exp_r) begin failures++; $display("FAIL lat3_rdata got=%h exp=%h", r, exp_r); end
            end
        end
        model(3, 32'h1C, 4'h0, 32'h0, exp_r, exp_er);
        access(3, 32'h1C, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_r) begin failures++; $display("FAIL lat3_ignored_write got=%h exp=%h", rd, exp_r); end
    endtask

    task automatic test_reset_mid_wait();
        logic a, d, b, e;
        logic [31:0] r, rd, exp_r;
        logic er, exp_er;
        int lat;
        model(3, 32'h8, 4'hF, 32'h13572468, exp_r, exp_er);
        access(3, 32'h8, 4'hF, 32'h13572468, rd, er, lat);
        drive(3, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        drive(3, 1'b0, 32'd0, 4'd0, 32'd0);
        observe(3, a, d, r, b, e);
        checks++; if (b !== 1'b1) begin failures++; $display("FAIL rstwait_pending_busy got=%b exp=1", b); end
        #1 rst = 1'b1;
        #1 observe(3, a, d, r, b, e);
        checks++; if (d !== 1'b0)  begin failures++; $display("FAIL rstwait_data_ok got=%b exp=0", d); end
        checks++; if (b !== 1'b0)  begin failures++; $display("FAIL rstwait_busy got=%b exp=0", b); end
        checks++; if (a !== 1'b1)  begin failures++; $display("FAIL rstwait_addr_ok got=%b exp=1", a); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL rstwait_rdata got=%h exp=0", r); end
        #1 rst = 1'b0;
        @(negedge clk);
        access(3, 32'h8, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h13572468) begin failures++; $display("FAIL rstwait_dropped_write got=%h exp=13572468", rd); end
    endtask

    task automatic test_range();
        logic [31:0] rd, exp_r, prior;
        logic er, exp_er;
        int lat;
        prior = sh1[0];
        model(1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, exp_r, exp_er);
        access(1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, rd, er, lat);
`ifdef DSRAM_RANGE_CHECK_EN
        checks++; if (er !== 1'b1)  begin failures++; $display("FAIL range_err got=%b exp=1", er); end
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL range_rdata got=%h exp=0", rd); end
        access(1, 32'h0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== prior) begin failures++; $display("FAIL range_suppressed got=%h exp=%h", rd, prior); end
        checks++; if (er !== 1'b0)  begin failures++; $display("FAIL range_err_clear got=%b exp=0", er); end
`else
        checks++; if (er !== 1'b0)  begin failures++; $display("FAIL alias_err got=%b exp=0", er); end
        checks++; if (rd !== prior) begin failures++; $display("FAIL alias_rdata got=%h exp=%h", rd, prior); end
        model(1, 32'h0, 4'h0, 32'h0, exp_r, exp_er);
        access(1, 32'h0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFFF) begin failures++; $display("FAIL alias_read got=%h exp=ffffffff", rd); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_r, addr, wdata;
        logic [3:0] wen;
        logic er, exp_er;
        int lat, sel;
        for (int n = 0; n < 40; n++) begin
            sel   = ($urandom_range(0, 1) == 0) ? 1 : 3;
            addr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            wen   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            wdata = $urandom;
            model(sel, addr, wen, wdata, exp_r, exp_er);
            access(sel, addr, wen, wdata, rd, er, lat);
            checks++; if (rd !== exp_r)  begin failures++; $display("FAIL rand_rdata n=%0d lat%0d addr=%h got=%h exp=%h", n, sel, addr, rd, exp_r); end
            checks++; if (lat !== sel)   begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, sel); end
            checks++; if (er !== exp_er) begin failures++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, er, exp_er); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word_rw();
        test_byte_lanes();
        test_back_to_back();
        test_latency3();
        test_reset_mid_wait();
        test_range();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
